// File: rtl/counter_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : counter_seq_checker
//  Description : Monitors the q output of a WIDTH-bit up/down counter and
//                checks that each sampled value is exactly one step from the
//                previous sample in the selected direction. It reports lock
//                status, issues single-cycle pulses for good steps, stalls,
//                wraps and errors, and keeps saturating wrap and error counts.
//
//  Ports       : clk         rising-edge system clock
//                rst         synchronous active-high reset
//                q_in        counter value under check     [WIDTH-1:0]
//                dir         0 = up expected, 1 = down expected
//                sample_en   sample q_in/dir on this edge
//                locked      1 while in LOCKED
//                step_ok     pulse: correct next step sampled
//                hold_pulse  pulse: sample equals previous sample
//                wrap_pulse  pulse: correct wrap step sampled
//                err_pulse   pulse: incorrect step sampled while LOCKED
//                wrap_count  saturating wrap count         [CNT_W-1:0]
//                err_count   saturating error count        [CNT_W-1:0]
//
//  Revision    : 1.0  initial release
// ============================================================================
module counter_seq_checker #(
    parameter int WIDTH  = 4,
    parameter int LOCK_N = 3,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] q_in,
    input  logic             dir,
    input  logic             sample_en,
    output logic             locked,
    output logic             step_ok,
    output logic             hold_pulse,
    output logic             wrap_pulse,
    output logic             err_pulse,
    output logic [CNT_W-1:0] wrap_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [1:0]       S_EMPTY   = 2'd0;
    localparam logic [1:0]       S_ACQUIRE = 2'd1;
    localparam logic [1:0]       S_LOCKED  = 2'd2;

    localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_ALL_ONES = '1;
    localparam logic [2:0]       C_LOCK_N   = 3'(LOCK_N);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;

    // Registered state
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_prev;
    logic             r_prev_dir;
    logic [1:0]       r_steps;
    logic             r_step_ok;
    logic             r_hold;
    logic             r_wrap;
    logic             r_err;
    logic [CNT_W-1:0] r_wrap_count;
    logic [CNT_W-1:0] r_err_count;

    // Next-state / pulse decode
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_prev_nxt;
    logic             w_dir_nxt;
    logic [1:0]       w_steps_nxt;
    logic             w_step_ok;
    logic             w_hold;
    logic             w_wrap;
    logic             w_err;
    logic [WIDTH-1:0] w_exp;
    logic             w_is_wrap;
    logic [2:0]       w_steps_inc;

    // Expected value wraps naturally modulo 2^WIDTH. A correct step taken
    // from the end of the range in the current direction is a wrap.
    assign w_exp       = r_prev_dir ? (r_prev - C_ONE) : (r_prev + C_ONE);
    assign w_is_wrap   = r_prev_dir ? (r_prev == '0) : (r_prev == C_ALL_ONES);
    // One extra bit so the compare against LOCK_N cannot alias on overflow
    assign w_steps_inc = {1'b0, r_steps} + 3'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev;
        w_dir_nxt   = r_prev_dir;
        w_steps_nxt = r_steps;
        w_step_ok   = 1'b0;
        w_hold      = 1'b0;
        w_wrap      = 1'b0;
        w_err       = 1'b0;

        if (sample_en) begin
            w_prev_nxt = q_in;
            case (r_state)
                S_EMPTY: begin
                    w_dir_nxt   = dir;
                    w_state_nxt = S_ACQUIRE;
                    w_steps_nxt = 2'd0;
                end
                S_ACQUIRE, S_LOCKED: begin
                    if (dir != r_prev_dir) begin
                        // Direction change is a resync, never an error
                        w_dir_nxt   = dir;
                        w_state_nxt = S_ACQUIRE;
                        w_steps_nxt = 2'd0;
                    end else if (q_in == w_exp) begin
                        w_step_ok = 1'b1;
                        w_wrap    = w_is_wrap;
                        if (r_state == S_ACQUIRE) begin
                            w_steps_nxt = w_steps_inc[1:0];
                            if (w_steps_inc >= C_LOCK_N) begin
                                w_state_nxt = S_LOCKED;
                            end
                        end
                    end else if (q_in == r_prev) begin
                        // Stalled counter: keep state and step count
                        w_hold = 1'b1;
                    end else begin
                        // Only a lost lock is reported; during acquisition
                        // a bad step just restarts the count.
                        w_err       = (r_state == S_LOCKED);
                        w_state_nxt = S_ACQUIRE;
                        w_steps_nxt = 2'd0;
                    end
                end
                default: begin
                    w_state_nxt = S_EMPTY;
                    w_steps_nxt = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_EMPTY;
            r_prev       <= '0;
            r_prev_dir   <= 1'b0;
            r_steps      <= 2'd0;
            r_step_ok    <= 1'b0;
            r_hold       <= 1'b0;
            r_wrap       <= 1'b0;
            r_err        <= 1'b0;
            r_wrap_count <= '0;
            r_err_count  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_prev     <= w_prev_nxt;
            r_prev_dir <= w_dir_nxt;
            r_steps    <= w_steps_nxt;
            r_step_ok  <= w_step_ok;
            r_hold     <= w_hold;
            r_wrap     <= w_wrap;
            r_err      <= w_err;
            // Counts saturate at all-ones while the pulses keep firing
            if (w_wrap && (r_wrap_count != C_CNT_MAX)) begin
                r_wrap_count <= r_wrap_count + C_CNT_ONE;
            end
            if (w_err && (r_err_count != C_CNT_MAX)) begin
                r_err_count <= r_err_count + C_CNT_ONE;
            end
        end
    end

    assign locked     = (r_state == S_LOCKED);
    assign step_ok    = r_step_ok;
    assign hold_pulse = r_hold;
    assign wrap_pulse = r_wrap;
    assign err_pulse  = r_err;
    assign wrap_count = r_wrap_count;
    assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_seq_checker
//  Description : Directed bench for counter_seq_checker. Two instances share
//                the same stimulus: one with 8-bit counts and one with 2-bit
//                counts so that saturation is observable. Expected outputs
//                are queued with each stimulus step and compared after the
//                following clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_counter_seq_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] q_in = '0;
    logic       dir = 1'b0;
    logic       sample_en = 1'b0;

    logic       a_locked, a_ok, a_hold, a_wrap, a_err;
    logic [7:0] a_wc, a_ec;
    logic       b_locked, b_ok, b_hold, b_wrap, b_err;
    logic [1:0] b_wc, b_ec;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       locked;
        logic       ok;
        logic       hold;
        logic       wrap;
        logic       err;
        logic [7:0] wc;
        logic [7:0] ec;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    counter_seq_checker #(.WIDTH(4), .LOCK_N(3), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .q_in(q_in), .dir(dir), .sample_en(sample_en),
        .locked(a_locked), .step_ok(a_ok), .hold_pulse(a_hold),
        .wrap_pulse(a_wrap), .err_pulse(a_err),
        .wrap_count(a_wc), .err_count(a_ec)
    );

    counter_seq_checker #(.WIDTH(4), .LOCK_N(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .q_in(q_in), .dir(dir), .sample_en(sample_en),
        .locked(b_locked), .step_ok(b_ok), .hold_pulse(b_hold),
        .wrap_pulse(b_wrap), .err_pulse(b_err),
        .wrap_count(b_wc), .err_count(b_ec)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sat2(input logic [7:0] v);
        return (v > 8'd3) ? 8'd3 : v;
    endfunction

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            chk("a_locked", {7'd0, a_locked}, {7'd0, e.locked});
            chk("a_step_ok", {7'd0, a_ok}, {7'd0, e.ok});
            chk("a_hold", {7'd0, a_hold}, {7'd0, e.hold});
            chk("a_wrap", {7'd0, a_wrap}, {7'd0, e.wrap});
            chk("a_err", {7'd0, a_err}, {7'd0, e.err});
            chk("a_wrap_count", a_wc, e.wc);
            chk("a_err_count", a_ec, e.ec);
            chk("b_locked", {7'd0, b_locked}, {7'd0, e.locked});
            chk("b_wrap", {7'd0, b_wrap}, {7'd0, e.wrap});
            chk("b_err", {7'd0, b_err}, {7'd0, e.err});
            chk("b_wrap_count", {6'd0, b_wc}, sat2(e.wc));
            chk("b_err_count", {6'd0, b_ec}, sat2(e.ec));
        end
    endtask

    // Drive one cycle of stimulus, queue its expected result, then compare
    // once the registered outputs have settled after the sampling edge.
    task automatic step(input logic r, input logic en, input logic d, input logic [3:0] q,
                        input logic l, input logic o, input logic h, input logic w,
                        input logic e, input int wc, input int ec);
        exp_t x;
        @(negedge clk);
        rst       = r;
        sample_en = en;
        dir       = d;
        q_in      = q;
        x.locked = l; x.ok = o; x.hold = h; x.wrap = w; x.err = e;
        x.wc = 8'(wc); x.ec = 8'(ec);
        sb.push_back(x);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wraps;
        int oks;
        logic [3:0] v;

        // Power-up reset
        step(1, 0, 0, 4'd0,  0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 4'd0,  0, 0, 0, 0, 0, 0, 0);

        // Up stream with wrap; lock on the third good step
        step(0, 1, 0, 4'd13, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 4'd14, 0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 4'd15, 0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 4'd0,  1, 1, 0, 1, 0, 1, 0);
        step(0, 1, 0, 4'd1,  1, 1, 0, 0, 0, 1, 0);

        // Skip while locked, then relock
        step(0, 1, 0, 4'd3,  0, 0, 0, 0, 1, 1, 1);
        step(0, 1, 0, 4'd4,  0, 1, 0, 0, 0, 1, 1);
        step(0, 1, 0, 4'd5,  0, 1, 0, 0, 0, 1, 1);
        step(0, 1, 0, 4'd6,  1, 1, 0, 0, 0, 1, 1);

        // Stall and gap while locked
        step(0, 1, 0, 4'd7,  1, 1, 0, 0, 0, 1, 1);
        step(0, 1, 0, 4'd7,  1, 0, 1, 0, 0, 1, 1);
        step(0, 1, 0, 4'd8,  1, 1, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 4'd3, 1, 0, 0, 0, 0, 1, 1);
        end
        step(0, 1, 0, 4'd9,  1, 1, 0, 0, 0, 1, 1);

        // Direction flip while locked, silent restart in acquisition
        step(0, 1, 1, 4'd10, 0, 0, 0, 0, 0, 1, 1);
        step(0, 1, 1, 4'd9,  0, 1, 0, 0, 0, 1, 1);
        step(0, 1, 1, 4'd5,  0, 0, 0, 0, 0, 1, 1);
        step(0, 1, 1, 4'd4,  0, 1, 0, 0, 0, 1, 1);
        step(0, 1, 1, 4'd3,  0, 1, 0, 0, 0, 1, 1);
        step(0, 1, 1, 4'd2,  1, 1, 0, 0, 0, 1, 1);

        // Mid-stream reset, with sample_en high on the second cycle
        step(1, 0, 0, 4'd0,  0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 4'd2,  0, 0, 0, 0, 0, 0, 0);

        // Down stream with wrap
        step(0, 1, 1, 4'd2,  0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 4'd1,  0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 4'd0,  0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 4'd15, 1, 1, 0, 1, 0, 1, 0);
        step(0, 1, 1, 4'd14, 1, 1, 0, 0, 0, 1, 0);

        // Four full up wraps: 8-bit count reaches 4, 2-bit count holds at 3
        step(1, 0, 0, 4'd0,  0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 4'd15, 0, 0, 0, 0, 0, 0, 0);
        wraps = 0;
        oks   = 0;
        for (int i = 0; i < 49; i++) begin
            v = 4'(i);
            oks++;
            if (v == 4'd0) wraps++;
            step(0, 1, 0, v, (oks >= 3), 1, 0, (v == 4'd0), 0, wraps, 0);
        end

        // Reset together with sample_en clears everything; next sample is
        // a first capture, so a value one above zero gives no step_ok.
        step(1, 1, 0, 4'd1,  0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 4'd1,  0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 4'd2,  0, 1, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
